req_priority_arbiter: RTL and testbench
=======================================

// Module: req_priority_arbiter
// PURPOSE
// - Shares one downstream resource between N requesters, using priority encoding.
// - Registers the chosen winner and holds its grant until that requester releases.
// - Enforces a maximum grant length so no single requester can hold the resource forever.
// - Sits between the request sources and the shared datapath; gnt_idx drives that datapath's select lines.
// PARAMETERS
// - N         8   number of requesters (2..16)
// - IDXW      3   width of gnt_idx; must equal clog2(N)
// - MAX_HOLD  16  maximum grant length in cycles (1..255); 0 means no limit
// PORTS
// - clk       in   1     single clock; all state changes on the rising edge
// - rst       in   1     synchronous reset, active-high
// - req       in   N     request lines; req[i] high means requester i wants the resource
// - gnt       out  N     one-hot grant, registered; all zero when idle
// - gnt_idx   out  IDXW  binary index of the granted requester; 0 when idle
// - gnt_valid out  1     high while any grant is active (equals |gnt)
// - timeout   out  1     one-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
// - Reset: rst is sampled at posedge clk.
//   - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
//   - state=IDLE, hold_cnt=0, last_idx=0, mask=0.
//   - Reset mid-grant revokes the grant on the next edge and discards all history.
// - FSM states: IDLE, GRANT.
//   - IDLE: if any (req & ~mask) is high, pick winner w by the priority order.
//     - Next cycle: gnt=1<<w, gnt_idx=w, state=GRANT, hold_cnt=1, mask=0.
//     - If only masked requesters are active, clear mask and stay IDLE; they arbitrate next cycle.
//   - GRANT, requester keeps req[gnt_idx]: keep the grant and increment hold_cnt.
//   - GRANT, normal release (req[gnt_idx]=0): gnt=0 and state=IDLE next cycle; mask=0.
//   - GRANT, limit reached (MAX_HOLD!=0, hold_cnt==MAX_HOLD, req still high):
//     - next cycle gnt=0, state=IDLE, timeout=1 for exactly one cycle;
//     - mask = one-hot of the revoked index.
// - Latency: a request is first seen in IDLE at edge k; gnt is asserted after edge k+1.
// - Dead cycle: every grant is followed by at least one IDLE cycle with gnt=0.
//   - Back-to-back grants are never adjacent.
// - A grant change never takes effect mid-grant.
//   - New higher-priority requests wait until the current holder releases.
// - Fixed priority: highest index wins (req[N-1] highest, req[0] lowest).
// - Simultaneous release and new request in the same cycle:
//   - the release takes effect first (dead cycle), then arbitration.
// - last_idx updates to w on every grant.
// - The hold counter saturates at MAX_HOLD and never wraps.
// - With MAX_HOLD=0: no counting, timeout stays 0.
// - Outputs are registered only; no combinational path from req to gnt.
// CONFIGURATION
// - Macro ROUND_ROBIN_EN.
//   - Defined: priority rotates. The search starts at (last_idx-1) mod N and goes downward, wrapping N-1 -> 0.
//   - Defined: the just-granted index is therefore lowest priority next time.
//   - Reset last_idx=0 gives the order N-1..0, the same as fixed priority at start-up.
//   - Not defined: fixed priority as above; last_idx is still kept for debug, with no effect on selection.
//   - Timeout masking applies in both modes.
// TESTING
// - Reset, single requester: req=8'h04 from cycle 0.
//   - gnt=8'h04, gnt_idx=2 from cycle 2.
//   - Drop req -> gnt=0 the next cycle.
// - Fixed priority, contention: req=8'h81.
//   - Grant goes to 7; releasing bit 7 -> one dead cycle, then gnt=8'h01, gnt_idx=0.
// - ROUND_ROBIN_EN, req=8'hFF held, each grantee drops req for 1 cycle after 2 cycles of grant:
//   - grant order is 7,6,5,...,0,7.
// - Timeout with MAX_HOLD=4, req=8'h30 held:
//   - idx5 holds for 4 cycles, then timeout pulses 1 cycle;
//   - next grant is idx4, even in fixed mode.
// - Assert rst during an active grant (idx3):
//   - all outputs 0 next cycle;
//   - with req still 8'h08, regrant 2 cycles after rst drops.
// - Check every cycle: gnt is one-hot or zero, gnt_valid==|gnt, gnt_idx matches gnt.

Source files
------------

// File: rtl/req_priority_arbiter.sv
// ---------------------------------------------------------------------------
// req_priority_arbiter
//
// Shares one downstream resource between N requesters. A winner is chosen by
// priority, registered, and held until that requester drops its request or
// until the grant has lasted MAX_HOLD cycles, whichever comes first. A revoked
// requester is masked for the next arbitration so the others get a turn.
// Every grant is followed by at least one idle cycle with gnt=0.
//
// Configuration macro:
//   ROUND_ROBIN_EN  defined   : search starts just below the last winner
//                               and wraps N-1 -> 0 (rotating priority).
//                   undefined : fixed priority, highest index wins.
//
// Parameters:
//   N         number of requesters (2..16)
//   IDXW      width of gnt_idx, equal to clog2(N)
//   MAX_HOLD  maximum grant length in cycles (1..255), 0 = unlimited
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   req        request lines, req[i]=1 means requester i wants the resource
//   gnt        one-hot grant (registered), zero when idle
//   gnt_idx    binary index of the granted requester, 0 when idle
//   gnt_valid  high while a grant is active (equals |gnt)
//   timeout    one-cycle pulse when a grant is revoked by MAX_HOLD
// ---------------------------------------------------------------------------
module req_priority_arbiter #(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [7:0] MAX_HOLD_C = MAX_HOLD[7:0];
    localparam logic       HOLD_EN    = (MAX_HOLD != 0);

    logic [0:0]      state_q,     state_d;
    logic [7:0]      hold_cnt_q,  hold_cnt_d;
    logic [IDXW-1:0] last_idx_q,  last_idx_d;
    logic [N-1:0]    mask_q,      mask_d;
    logic [N-1:0]    req_q,       req_d;
    logic [N-1:0]    gnt_q,       gnt_d;
    logic [IDXW-1:0] gnt_idx_q,   gnt_idx_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            timeout_q,   timeout_d;

    // Arbitration works on the captured request vector so the priority tree
    // starts from a flop rather than from the input pins.
    logic [N-1:0]    cand_s;
    logic            win_found_s;
    logic [IDXW-1:0] win_idx_s;

    // Requesters still eligible after removing a just-revoked holder.
    always_comb begin
        cand_s = req_q & ~mask_q;
    end

`ifdef ROUND_ROBIN_EN
    localparam logic [IDXW:0] N_W = (IDXW+1)'(N);

    logic [IDXW-1:0] rr_start_s;
    logic [IDXW:0]   rank_s [N];
    logic [IDXW:0]   best_rank_s;

    // Search start is one below the previous winner, wrapping 0 -> N-1.
    always_comb begin
        if (last_idx_q == '0) begin
            rr_start_s = IDXW'(N - 1);
        end else begin
            rr_start_s = last_idx_q - IDXW'(1);
        end
    end

    // Rank of each index = downward distance from the search start (0 is best).
    always_comb begin
        for (int j = 0; j < N; j++) begin
            if ({1'b0, rr_start_s} >= (IDXW+1)'(j)) begin
                rank_s[j] = {1'b0, rr_start_s} - (IDXW+1)'(j);
            end else begin
                rank_s[j] = {1'b0, rr_start_s} + N_W - (IDXW+1)'(j);
            end
        end
    end

    // Pick the eligible requester with the smallest rank.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        best_rank_s = '1;
        for (int j = 0; j < N; j++) begin
            if (cand_s[j] && (!win_found_s || (rank_s[j] < best_rank_s))) begin
                win_found_s = 1'b1;
                win_idx_s   = IDXW'(j);
                best_rank_s = rank_s[j];
            end else begin
                best_rank_s = best_rank_s;
            end
        end
    end
`else
    // Fixed priority: scanning upward lets the highest eligible index win.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int j = 0; j < N; j++) begin
            if (cand_s[j]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDXW'(j);
            end else begin
                win_idx_s   = win_idx_s;
            end
        end
    end
`endif

    // Grant FSM: IDLE arbitrates, GRANT holds until release or hold limit.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_idx_d = last_idx_q;
        mask_d     = mask_q;
        req_d      = req;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d           = ST_GRANT;
                    gnt_d             = '0;
                    gnt_d[win_idx_s]  = 1'b1;
                    gnt_idx_d         = win_idx_s;
                    hold_cnt_d        = 8'd1;
                    mask_d            = '0;
                    last_idx_d        = win_idx_s;
                end else if (|req_q) begin
                    // Only the masked requester is asking: unmask it so it
                    // competes normally on the next cycle.
                    mask_d = '0;
                end else begin
                    mask_d = mask_q;
                end
            end
            ST_GRANT: begin
                // Release is observed on the live request bit so the holder
                // is never regranted off a stale captured request.
                if (!req[gnt_idx_q]) begin
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    gnt_idx_d  = '0;
                    hold_cnt_d = 8'd0;
                    mask_d     = '0;
                end else if (HOLD_EN && (hold_cnt_q == MAX_HOLD_C)) begin
                    state_d           = ST_IDLE;
                    gnt_d             = '0;
                    gnt_idx_d         = '0;
                    hold_cnt_d        = 8'd0;
                    mask_d            = '0;
                    mask_d[gnt_idx_q] = 1'b1;
                    timeout_d         = 1'b1;
                end else if (HOLD_EN) begin
                    // The limit branch above fires at MAX_HOLD, so this
                    // increment can never pass it or wrap.
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = '0;
                gnt_idx_d  = '0;
                hold_cnt_d = 8'd0;
                mask_d     = '0;
            end
        endcase

        gnt_valid_d = |gnt_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= 8'd0;
            last_idx_q  <= '0;
            mask_q      <= '0;
            req_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            last_idx_q  <= last_idx_d;
            mask_q      <= mask_d;
            req_q       <= req_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tb_req_priority_arbiter
// Directed stimulus with hand-computed expectations, plus a cycle model of the
// arbiter (owner / hold count / mask held as plain integers) compared against
// the DUT on every falling edge.
// ---------------------------------------------------------------------------
module tb_req_priority_arbiter;

    localparam int N    = 8;
    localparam int IDXW = 3;
    localparam int MAXH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            timeout;

    int n_checks = 0;
    int n_fail   = 0;

    req_priority_arbiter #(.N(N), .IDXW(IDXW), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int           m_owner = -1;   // granted index, -1 when idle
    int           m_hold  = 0;
    int           m_last  = 0;
    logic [N-1:0] m_mask  = '0;
    logic [N-1:0] m_rq    = '0;   // request vector seen one edge earlier
    logic         m_tmo   = 1'b0;
    bit           m_live  = 1'b0;

    function automatic int pick(input logic [N-1:0] c, input int last);
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (((last - k) % N) + N) % N;
            if (c[i]) return i;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (c[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    always @(posedge clk) begin : model_b
        int           nx_owner, nx_hold, nx_last, w;
        logic [N-1:0] nx_mask;
        logic         nx_tmo;
        if (rst) begin
            m_owner <= -1;
            m_hold  <= 0;
            m_last  <= 0;
            m_mask  <= '0;
            m_rq    <= '0;
            m_tmo   <= 1'b0;
            m_live  <= 1'b1;
        end else begin
            nx_owner = m_owner;
            nx_hold  = m_hold;
            nx_last  = m_last;
            nx_mask  = m_mask;
            nx_tmo   = 1'b0;
            if (m_owner < 0) begin
                w = pick(m_rq & ~m_mask, m_last);
                if (w >= 0) begin
                    nx_owner = w;
                    nx_hold  = 1;
                    nx_mask  = '0;
                    nx_last  = w;
                end else if (m_rq != '0) begin
                    nx_mask = '0;
                end
            end else if (!req[m_owner]) begin
                nx_owner = -1;
                nx_mask  = '0;
            end else if (MAXH != 0 && m_hold >= MAXH) begin
                nx_mask          = '0;
                nx_mask[m_owner] = 1'b1;
                nx_owner         = -1;
                nx_tmo           = 1'b1;
            end else begin
                nx_hold = m_hold + 1;
            end
            m_owner <= nx_owner;
            m_hold  <= nx_hold;
            m_last  <= nx_last;
            m_mask  <= nx_mask;
            m_rq    <= req;
            m_tmo   <= nx_tmo;
        end
    end

    // Per-cycle compare against the model plus structural invariants.
    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_gnt",     gnt,       model_gnt());
            check("cyc_gnt_idx", gnt_idx,   (m_owner >= 0) ? m_owner : 0);
            check("cyc_valid",   gnt_valid, (m_owner >= 0) ? 1 : 0);
            check("cyc_timeout", timeout,   m_tmo);
            check("inv_onehot0", $onehot0(gnt), 1);
            check("inv_valid_or", gnt_valid, |gnt);
            if (gnt == '0) check("inv_idx_idle", gnt_idx, 0);
            else           check("inv_idx_match", gnt, (32'd1 << gnt_idx));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect grant to idx (or idle when idx<0) and the given timeout value,
    // on both the DUT and the model.
    task automatic lit(input string nm, input int idx, input logic tmo);
        logic [N-1:0] g;
        g = '0;
        if (idx >= 0) g[idx] = 1'b1;
        check({nm, "_gnt"},     gnt,     g);
        check({nm, "_idx"},     gnt_idx, (idx >= 0) ? idx : 0);
        check({nm, "_timeout"}, timeout, tmo);
        check({nm, "_model"},   model_gnt(), g);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        lit("reset", -1, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] drop;
        int           exp_idx;

        // Single requester: gnt from cycle 2, released the cycle after drop.
        do_reset();
        req = 8'h04;
        tick(); lit("single_c1", -1, 1'b0);
        tick(); lit("single_c2", 2, 1'b0);
        tick(); lit("single_c3", 2, 1'b0);
        req = 8'h00;
        tick(); lit("single_rel", -1, 1'b0);
        tick(); lit("single_idle", -1, 1'b0);

        // Contention 0x81: idx 7 first, one dead cycle, then idx 0.
        do_reset();
        req = 8'h81;
        tick(); lit("cont_c1", -1, 1'b0);
        tick(); lit("cont_g7", 7, 1'b0);
        req = 8'h01;
        tick(); lit("cont_dead", -1, 1'b0);
        tick(); lit("cont_g0", 0, 1'b0);
        req = 8'h00;
        tick(); lit("cont_rel", -1, 1'b0);

        // Hold limit 4 with 0x30 held: idx5 for 4 cycles, pulse, then idx4.
        do_reset();
        req = 8'h30;
        tick(); lit("tmo_c1", -1, 1'b0);
        tick(); lit("tmo_h1", 5, 1'b0);
        tick(); lit("tmo_h2", 5, 1'b0);
        tick(); lit("tmo_h3", 5, 1'b0);
        tick(); lit("tmo_h4", 5, 1'b0);
        tick(); lit("tmo_pulse", -1, 1'b1);
        tick(); lit("tmo_g4", 4, 1'b0);
        tick(); lit("tmo_g4b", 4, 1'b0);
        req = 8'h00;
        tick(); lit("tmo_rel", -1, 1'b0);
        tick();

        // Reset during an idx3 grant, regrant 2 cycles after rst drops.
        do_reset();
        req = 8'h08;
        tick(); lit("rst_c1", -1, 1'b0);
        tick(); lit("rst_g3", 3, 1'b0);
        rst = 1'b1;
        tick(); lit("rst_kill", -1, 1'b0);
        rst = 1'b0;
        tick(); lit("rst_c1b", -1, 1'b0);
        tick(); lit("rst_regrant", 3, 1'b0);
        req = 8'h00;
        tick();
        tick();

        // All requesting, each holder drops for one cycle after 2 grant cycles.
        do_reset();
        req = 8'hFF;
        tick(); lit("rot_c1", -1, 1'b0);
        tick();
        for (int i = 0; i <= N; i++) begin
`ifdef ROUND_ROBIN_EN
            exp_idx = (7 - i + N) % N;
`else
            exp_idx = (i % 2 == 0) ? 7 : 6;
`endif
            lit($sformatf("rot%0d_g1", i), exp_idx, 1'b0);
            tick();
            lit($sformatf("rot%0d_g2", i), exp_idx, 1'b0);
            drop          = '0;
            drop[exp_idx] = 1'b1;
            req           = ~drop;
            tick();
            lit($sformatf("rot%0d_dead", i), -1, 1'b0);
            req = 8'hFF;
            tick();
        end
        req = 8'h00;
        tick();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual time %0t", $time);
        $fatal(1);
    end

endmodule
